alu_ab_datapath: RTL and testbench

4-bit accumulator datapath for the SAP-style CPU. Contains the A register (accumulator), the B register, and a clocked ALU. It sits between RAM, the TMP register, the flag register and the OUT register, and is driven by control-sequencer strobes. All internal buses are point-to-point. Output enables gate a bus to zero when deasserted; there are no tri-states.

---
 rtl/alu_ab_datapath_pkg.sv | 23 ++
 rtl/alu_ab_datapath_if.sv | 28 ++
 rtl/alu_ab_datapath_alu_core.sv | 37 +++
 rtl/alu_ab_datapath.sv | 71 +++++++
 tb/tb_alu_ab_datapath.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/alu_ab_datapath_pkg.sv
// Shared CPU constants: data width, ALU/system opcodes and the ALU output bundle.
package cpu_pkg;
  localparam int W = 4;

  localparam logic [3:0] HLT        = 4'b0000;
  localparam logic [3:0] OP_ADD     = 4'b0001;
  localparam logic [3:0] OP_SUB     = 4'b0010;
  localparam logic [3:0] OP_AND     = 4'b0011;
  localparam logic [3:0] OP_OR      = 4'b0100;
  localparam logic [3:0] OP_XOR     = 4'b0101;
  localparam logic [3:0] OP_NOT     = 4'b0110;
  localparam logic [3:0] MOV_A_ADDR = 4'b0111;
  localparam logic [3:0] OP_INC     = 4'b1000;
  localparam logic [3:0] OP_DEC     = 4'b1001;
  localparam logic [3:0] OUT_A      = 4'b1010;
  localparam logic [3:0] OP_ADT     = 4'b1011;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
  } alu_out_t;
endpackage

// File: rtl/alu_ab_datapath_if.sv
// Sequencer-side bundle for the A/B/ALU datapath: operands, strobes and gated outputs.
interface alu_ab_datapath_if #(parameter int W = cpu_pkg::W);
  logic [3:0]   opcode;
  logic [W-1:0] ram_to_a, ram_to_b, tmp_to_b, tmp_to_alu;
  logic         carry_in;
  logic         la_ram, la_b, la_alu;
  logic         ea_tmp, ea_ram, ea_out, ea_carry;
  logic         lb_tmp, lb_alu, lb_pop, lb_carry;
  logic         eb_a, eb_push, ercl, eu;
  logic [W-1:0] a_to_tmp, a_to_ram, a_to_out, b_to_ram;
  logic         carry_from_a, carry_from_b, carry_to_reg, zero, carry;

  modport master (
    output opcode, ram_to_a, ram_to_b, tmp_to_b, tmp_to_alu, carry_in,
           la_ram, la_b, la_alu, ea_tmp, ea_ram, ea_out, ea_carry,
           lb_tmp, lb_alu, lb_pop, lb_carry, eb_a, eb_push, ercl, eu,
    input  a_to_tmp, a_to_ram, a_to_out, b_to_ram,
           carry_from_a, carry_from_b, carry_to_reg, zero, carry
  );

  modport slave (
    input  opcode, ram_to_a, ram_to_b, tmp_to_b, tmp_to_alu, carry_in,
           la_ram, la_b, la_alu, ea_tmp, ea_ram, ea_out, ea_carry,
           lb_tmp, lb_alu, lb_pop, lb_carry, eb_a, eb_push, ercl, eu,
    output a_to_tmp, a_to_ram, a_to_out, b_to_ram,
           carry_from_a, carry_from_b, carry_to_reg, zero, carry
  );
endinterface

// File: rtl/alu_ab_datapath_alu_core.sv
// Combinational ALU: result, carry/borrow and zero for one opcode; registered by the top.
module alu_core
  import cpu_pkg::*;
(
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] tmp,
  output alu_out_t     y
);
  logic [W:0]   ext;
  logic [W-1:0] res;
  logic         c;

  // ext[W] is carry-out for adds and the borrow for subtracts.
  always_comb begin
    ext = '0;
    res = a;
    c   = 1'b0;
    case (op)
      OP_ADD: begin ext = {1'b0, a} + {1'b0, b};       res = ext[W-1:0]; c = ext[W]; end
      OP_SUB: begin ext = {1'b0, a} - {1'b0, b};       res = ext[W-1:0]; c = ext[W]; end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_INC: begin ext = {1'b0, a} + (W+1)'(1);       res = ext[W-1:0]; c = ext[W]; end
      OP_DEC: begin ext = {1'b0, a} - (W+1)'(1);       res = ext[W-1:0]; c = ext[W]; end
      OP_ADT: begin ext = {1'b0, a} + {1'b0, tmp};     res = ext[W-1:0]; c = ext[W]; end
      default: res = a;
    endcase
  end

  assign y.res = res;
  assign y.c   = c;
  assign y.z   = (res == '0);
endmodule

// File: rtl/alu_ab_datapath.sv
// A/B registers plus clocked ALU; outputs are zero-gated copies of register state.
module alu_ab_datapath
  import cpu_pkg::*;
(
  input logic              clk,
  input logic              reset,
  alu_ab_datapath_if.slave bus
);
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic         zero_q, zero_d, carry_q, carry_d;
  alu_out_t     alu_y;
  logic         unused_eb_a;

  // B-to-A transfer is internal and keyed only by la_b.
  assign unused_eb_a = bus.eb_a;

  alu_core u_alu (.op(bus.opcode), .a(a_q), .b(b_q), .tmp(bus.tmp_to_alu), .y(alu_y));

  always_comb begin
    a_d = a_q;
    if      (bus.la_ram) a_d = bus.ram_to_a;
    else if (bus.la_b)   a_d = b_q;
    else if (bus.la_alu) a_d = res_q;
  end

  always_comb begin
    b_d = b_q;
    if      (bus.lb_pop)   b_d = bus.ram_to_b;
    else if (bus.lb_tmp)   b_d = bus.tmp_to_b;
    else if (bus.lb_alu)   b_d = res_q;
    else if (bus.lb_carry) b_d = {{(W-1){1'b0}}, bus.carry_in};
    else if (bus.ercl)     b_d = {b_q[W-2:0], bus.carry_in};
  end

  always_comb begin
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (bus.eu) begin
      res_d   = alu_y.res;
      zero_d  = alu_y.z;
      carry_d = alu_y.c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign bus.a_to_tmp     = bus.ea_tmp  ? a_q : '0;
  assign bus.a_to_ram     = bus.ea_ram  ? a_q : '0;
  assign bus.a_to_out     = bus.ea_out  ? a_q : '0;
  assign bus.b_to_ram     = bus.eb_push ? b_q : '0;
  assign bus.carry_from_a = bus.ea_carry & a_q[0];
  assign bus.carry_from_b = b_q[0];
  assign bus.carry_to_reg = bus.ercl & b_q[W-1];
  assign bus.zero         = zero_q;
  assign bus.carry        = carry_q;
endmodule

// File: tb/tb_alu_ab_datapath.sv
// Scenario bench for alu_ab_datapath with a queued reference model for the ALU sweep.
module tb_alu_ab_datapath;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_ab_datapath_if bus();
  alu_ab_datapath dut (.clk(clk), .reset(reset), .bus(bus));

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {logic [3:0] res; logic c; logic z;} exp_t;
  exp_t exp_q[$];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    bus.opcode = 4'h0; bus.ram_to_a = '0; bus.ram_to_b = '0; bus.tmp_to_b = '0;
    bus.tmp_to_alu = '0; bus.carry_in = 1'b0;
    bus.la_ram = 0; bus.la_b = 0; bus.la_alu = 0;
    bus.ea_tmp = 0; bus.ea_ram = 0; bus.ea_out = 0; bus.ea_carry = 0;
    bus.lb_tmp = 0; bus.lb_alu = 0; bus.lb_pop = 0; bus.lb_carry = 0;
    bus.eb_a = 0; bus.eb_push = 0; bus.ercl = 0; bus.eu = 0;
  endtask

  task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
    bus.ram_to_a = a; bus.la_ram = 1; bus.ram_to_b = b; bus.lb_pop = 1;
    tick();
    bus.la_ram = 0; bus.lb_pop = 0;
  endtask

  function automatic exp_t model(input logic [3:0] op, input int a, input int b, input int t);
    exp_t e; int r;
    e.c = 1'b0; r = a;
    case (op)
      4'd1:  begin r = a + b; e.c = (r > 15); end
      4'd2:  begin r = a - b; e.c = (a < b);  end
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = 15 - a;
      4'd8:  begin r = a + 1; e.c = (a == 15); end
      4'd9:  begin r = a - 1; e.c = (a == 0);  end
      4'd11: begin r = a + t; e.c = (r > 15); end
      default: r = a;
    endcase
    e.res = 4'(r & 15);
    e.z   = (e.res == 4'h0);
    return e;
  endfunction

  task automatic test_reset();
    idle(); reset = 1; tick();
    bus.ea_out = 1; bus.eb_push = 1; #1;
    vec_cnt++; if (bus.a_to_out !== 4'h0) begin err_cnt++; $display("FAIL rst_init_a got=%h exp=0", bus.a_to_out); end
    vec_cnt++; if ({bus.zero, bus.carry} !== 2'b00) begin err_cnt++; $display("FAIL rst_init_flags got=%b exp=00", {bus.zero, bus.carry}); end
    reset = 0;
    load_ab(4'h3, 4'h7);
    bus.opcode = 4'b0010; bus.eu = 1; tick(); bus.eu = 0;
    load_ab(4'h7, 4'h3); #1;
    vec_cnt++; if ({bus.a_to_out, bus.b_to_ram, bus.carry} !== {4'h7, 4'h3, 1'b1}) begin
      err_cnt++; $display("FAIL rst_pre got a=%h b=%h c=%b exp a=7 b=3 c=1", bus.a_to_out, bus.b_to_ram, bus.carry); end
    #1 reset = 1; #1;
    vec_cnt++; if ({bus.a_to_out, bus.b_to_ram, bus.zero, bus.carry} !== 10'h0) begin
      err_cnt++; $display("FAIL rst_async got a=%h b=%h z=%b c=%b exp all 0", bus.a_to_out, bus.b_to_ram, bus.zero, bus.carry); end
    tick(); reset = 0;
    bus.la_alu = 1; tick(); bus.la_alu = 0;
    vec_cnt++; if (bus.a_to_out !== 4'h0) begin err_cnt++; $display("FAIL rst_result got=%h exp=0", bus.a_to_out); end
  endtask

  task automatic test_load_out();
    idle(); bus.ram_to_a = 4'h1; bus.la_ram = 1; bus.ea_out = 1;
    tick(); bus.la_ram = 0;
    vec_cnt++; if (bus.a_to_out !== 4'h1) begin err_cnt++; $display("FAIL load_out_on got=%h exp=1", bus.a_to_out); end
    bus.ea_out = 0; #1;
    vec_cnt++; if (bus.a_to_out !== 4'h0) begin err_cnt++; $display("FAIL load_out_off got=%h exp=0", bus.a_to_out); end
    bus.ea_tmp = 1; bus.ea_ram = 1; bus.ea_carry = 1; #1;
    vec_cnt++; if ({bus.a_to_tmp, bus.a_to_ram, bus.carry_from_a} !== {4'h1, 4'h1, 1'b1}) begin
      err_cnt++; $display("FAIL load_gates got tmp=%h ram=%h cfa=%b exp 1 1 1", bus.a_to_tmp, bus.a_to_ram, bus.carry_from_a); end
    bus.ea_carry = 0; #1;
    vec_cnt++; if (bus.carry_from_a !== 1'b0) begin err_cnt++; $display("FAIL cfa_off got=%b exp=0", bus.carry_from_a); end
  endtask

  task automatic test_add();
    idle(); bus.ram_to_a = 4'h8; bus.la_ram = 1; bus.tmp_to_b = 4'h9; bus.lb_tmp = 1;
    tick(); bus.la_ram = 0; bus.lb_tmp = 0;
    bus.opcode = 4'b0001; bus.eu = 1; tick(); bus.eu = 0;
    vec_cnt++; if ({bus.carry, bus.zero} !== 2'b10) begin err_cnt++; $display("FAIL add_flags got c=%b z=%b exp c=1 z=0", bus.carry, bus.zero); end
    bus.la_alu = 1; bus.ea_out = 1; tick(); bus.la_alu = 0;
    vec_cnt++; if (bus.a_to_out !== 4'h1) begin err_cnt++; $display("FAIL add_res got=%h exp=1", bus.a_to_out); end
  endtask

  task automatic test_sub();
    idle(); load_ab(4'h5, 4'h5);
    bus.opcode = 4'b0010; bus.eu = 1; tick(); bus.eu = 0;
    vec_cnt++; if ({bus.zero, bus.carry} !== 2'b10) begin err_cnt++; $display("FAIL sub_eq got z=%b c=%b exp z=1 c=0", bus.zero, bus.carry); end
    load_ab(4'h3, 4'h5);
    bus.eu = 1; tick(); bus.eu = 0;
    vec_cnt++; if ({bus.zero, bus.carry} !== 2'b01) begin err_cnt++; $display("FAIL sub_borrow got z=%b c=%b exp z=0 c=1", bus.zero, bus.carry); end
    bus.la_alu = 1; bus.ea_out = 1; tick(); bus.la_alu = 0;
    vec_cnt++; if (bus.a_to_out !== 4'hE) begin err_cnt++; $display("FAIL sub_res got=%h exp=e", bus.a_to_out); end
  endtask

  task automatic test_rotate();
    idle(); load_ab(4'h0, 4'b1001);
    bus.carry_in = 1; bus.ercl = 1; #1;
    vec_cnt++; if (bus.carry_to_reg !== 1'b1) begin err_cnt++; $display("FAIL rcl_out got=%b exp=1", bus.carry_to_reg); end
    tick(); bus.ercl = 0; bus.eb_push = 1; #1;
    vec_cnt++; if ({bus.b_to_ram, bus.carry_to_reg, bus.carry_from_b} !== {4'b0011, 1'b0, 1'b1}) begin
      err_cnt++; $display("FAIL rcl_b got b=%b ctr=%b cfb=%b exp 0011 0 1", bus.b_to_ram, bus.carry_to_reg, bus.carry_from_b); end
    bus.carry_in = 0; bus.lb_carry = 1; tick(); bus.lb_carry = 0;
    vec_cnt++; if ({bus.b_to_ram, bus.carry_from_b} !== 5'h0) begin
      err_cnt++; $display("FAIL lb_carry got b=%b cfb=%b exp 0000 0", bus.b_to_ram, bus.carry_from_b); end
  endtask

  task automatic test_priority();
    idle(); load_ab(4'h0, 4'h0);
    bus.opcode = 4'b1001; bus.eu = 1; tick(); bus.eu = 0;
    vec_cnt++; if ({bus.carry, bus.zero} !== 2'b10) begin err_cnt++; $display("FAIL dec_wrap got c=%b z=%b exp c=1 z=0", bus.carry, bus.zero); end
    bus.ram_to_a = 4'h6; bus.la_ram = 1; bus.la_alu = 1; bus.ea_out = 1; tick(); bus.la_ram = 0;
    vec_cnt++; if (bus.a_to_out !== 4'h6) begin err_cnt++; $display("FAIL prio_ram got=%h exp=6", bus.a_to_out); end
    tick(); bus.la_alu = 0;
    vec_cnt++; if (bus.a_to_out !== 4'hF) begin err_cnt++; $display("FAIL prio_hold got=%h exp=f", bus.a_to_out); end
  endtask

  task automatic test_back_to_back();
    idle(); load_ab(4'h2, 4'h3);
    bus.opcode = 4'b0001; bus.eu = 1; bus.la_alu = 1; bus.ea_out = 1; tick(); bus.eu = 0;
    vec_cnt++; if (bus.a_to_out !== 4'hF) begin err_cnt++; $display("FAIL b2b_prev got=%h exp=f", bus.a_to_out); end
    tick(); bus.la_alu = 0;
    vec_cnt++; if (bus.a_to_out !== 4'h5) begin err_cnt++; $display("FAIL b2b_new got=%h exp=5", bus.a_to_out); end
    load_ab(4'h1, 4'hC);
    bus.tmp_to_b = 4'h4; bus.la_b = 1; bus.lb_tmp = 1; bus.eb_push = 1; tick(); bus.la_b = 0; bus.lb_tmp = 0;
    vec_cnt++; if ({bus.a_to_out, bus.b_to_ram} !== {4'hC, 4'h4}) begin
      err_cnt++; $display("FAIL swap got a=%h b=%h exp a=c b=4", bus.a_to_out, bus.b_to_ram); end
  endtask

  task automatic test_ops();
    exp_t e;
    idle();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op, a, b, t;
      op = (i < 16) ? 4'(i) : 4'($urandom_range(15, 0));
      a = 4'($urandom_range(15, 0)); b = 4'($urandom_range(15, 0)); t = 4'($urandom_range(15, 0));
      if (i == 16) begin op = 4'b1000; a = 4'hF; end
      load_ab(a, b);
      bus.tmp_to_alu = t; bus.opcode = op; bus.eu = 1;
      exp_q.push_back(model(op, int'(a), int'(b), int'(t)));
      tick(); bus.eu = 0;
      bus.la_alu = 1; bus.ea_out = 1; tick(); bus.la_alu = 0;
      e = exp_q.pop_front();
      vec_cnt++; if ({bus.a_to_out, bus.carry, bus.zero} !== {e.res, e.c, e.z}) begin
        err_cnt++; $display("FAIL op%h a=%h b=%h t=%h got r=%h c=%b z=%b exp r=%h c=%b z=%b",
                            op, a, b, t, bus.a_to_out, bus.carry, bus.zero, e.res, e.c, e.z); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_out();
    test_add();
    test_sub();
    test_rotate();
    test_priority();
    test_back_to_back();
    test_ops();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
